// File: rtl/sprite_layer_scheduler.sv
// Per-pixel sprite scheduler: double-banked slot positions with a once-per-frame
// commit, fixed-priority hit resolution and a registered output stage.
module sprite_layer_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int SPRITE_W  = 16,
    parameter int SPRITE_H  = 16,
    localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [SLOT_W-1:0] cfg_slot,
    input  logic [9:0]        cfg_x,
    input  logic [9:0]        cfg_y,
    input  logic              cfg_en,
    output logic [9:0]        RelativeXM,
    output logic [9:0]        RelativeYM,
    output logic [SLOT_W-1:0] sprite_sel,
    output logic              sprite_hit,
    output logic              layer_hit,
    output logic              commit_done,
    output logic [0:0]        state_dbg
);

    // Config handshake: a write transfers on any rising vga_clk edge where
    // cfg_valid && cfg_ready; the requester holds cfg_slot/x/y/en until then.
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    logic [0:0] state_q, state_d;

    logic [9:0] sh_x_q  [NUM_SLOTS];
    logic [9:0] sh_x_d  [NUM_SLOTS];
    logic [9:0] sh_y_q  [NUM_SLOTS];
    logic [9:0] sh_y_d  [NUM_SLOTS];
    logic       sh_en_q [NUM_SLOTS];
    logic       sh_en_d [NUM_SLOTS];
    logic [9:0] act_x_q [NUM_SLOTS];
    logic [9:0] act_x_d [NUM_SLOTS];
    logic [9:0] act_y_q [NUM_SLOTS];
    logic [9:0] act_y_d [NUM_SLOTS];
    logic       act_en_q[NUM_SLOTS];
    logic       act_en_d[NUM_SLOTS];

    logic              hit_q, hit_d;
    logic [SLOT_W-1:0] sel_q, sel_d;
    logic [9:0]        rel_x_q, rel_x_d;
    logic [9:0]        rel_y_q, rel_y_d;
    logic              lh1_q, lh1_d;
    logic              lh2_q, lh2_d;

    logic              cfg_fire;
    logic [NUM_SLOTS-1:0] hit_vec;
    logic              any_hit;
    logic [SLOT_W-1:0] win;

    assign cfg_ready   = (state_q == ST_RUN);
    assign commit_done = (state_q == ST_COMMIT);
    assign cfg_fire    = cfg_valid && cfg_ready;
    assign state_dbg   = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (frame_start) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // A write in the frame_start cycle lands in shadow before the COMMIT copy.
    always_comb begin
        sh_x_d   = sh_x_q;
        sh_y_d   = sh_y_q;
        sh_en_d  = sh_en_q;
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        act_en_d = act_en_q;
        if (cfg_fire) begin
            sh_x_d[cfg_slot]  = cfg_x;
            sh_y_d[cfg_slot]  = cfg_y;
            sh_en_d[cfg_slot] = cfg_en;
        end
        if (state_q == ST_COMMIT) begin
            act_x_d  = sh_x_q;
            act_y_d  = sh_y_q;
            act_en_d = sh_en_q;
        end
    end

    // 11-bit bounds so a sprite near 1023 never wraps back to column 0.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit_vec[i] = act_en_q[i]
                && ({1'b0, DrawX} >= {1'b0, act_x_q[i]})
                && ({1'b0, DrawX} <  ({1'b0, act_x_q[i]} + 11'(SPRITE_W)))
                && ({1'b0, DrawY} >= {1'b0, act_y_q[i]})
                && ({1'b0, DrawY} <  ({1'b0, act_y_q[i]} + 11'(SPRITE_H)));
        end
    end

    always_comb begin
        any_hit = 1'b0;
        win     = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                any_hit = 1'b1;
                win     = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        hit_d   = any_hit && blank;
        sel_d   = '0;
        rel_x_d = '0;
        rel_y_d = '0;
        if (any_hit) begin
            sel_d   = win;
            rel_x_d = DrawX - act_x_q[win];
            rel_y_d = DrawY - act_y_q[win];
        end
        lh1_d = hit_q;
        lh2_d = lh1_q;
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                sh_x_q[i]   <= '0;
                sh_y_q[i]   <= '0;
                sh_en_q[i]  <= 1'b0;
                act_x_q[i]  <= '0;
                act_y_q[i]  <= '0;
                act_en_q[i] <= 1'b0;
            end
            hit_q   <= 1'b0;
            sel_q   <= '0;
            rel_x_q <= '0;
            rel_y_q <= '0;
            lh1_q   <= 1'b0;
            lh2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_x_q   <= sh_x_d;
            sh_y_q   <= sh_y_d;
            sh_en_q  <= sh_en_d;
            act_x_q  <= act_x_d;
            act_y_q  <= act_y_d;
            act_en_q <= act_en_d;
            hit_q    <= hit_d;
            sel_q    <= sel_d;
            rel_x_q  <= rel_x_d;
            rel_y_q  <= rel_y_d;
            lh1_q    <= lh1_d;
            lh2_q    <= lh2_d;
        end
    end

    assign sprite_hit = hit_q;
    assign sprite_sel = sel_q;
    assign RelativeXM = rel_x_q;
    assign RelativeYM = rel_y_q;
    assign layer_hit  = lh2_q;

endmodule

// File: tb/tb_sprite_layer_scheduler.sv
// Directed bench for sprite_layer_scheduler: commit timing, priority, edges,
// shadow isolation and config/commit handshake collisions.
module tb_sprite_layer_scheduler;

    logic       vga_clk = 1'b0;
    logic       Reset;
    logic       frame_start;
    logic [9:0] DrawX, DrawY;
    logic       blank;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_slot;
    logic [9:0] cfg_x, cfg_y;
    logic       cfg_en;
    logic [9:0] RelativeXM, RelativeYM;
    logic [1:0] sprite_sel;
    logic       sprite_hit;
    logic       layer_hit;
    logic       commit_done;
    logic [0:0] state_dbg;

    int total = 0;
    int bad   = 0;
    int cd_cnt = 0;

    sprite_layer_scheduler #(.NUM_SLOTS(4), .SPRITE_W(16), .SPRITE_H(16)) dut (
        .vga_clk(vga_clk), .Reset(Reset), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_slot(cfg_slot),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en),
        .RelativeXM(RelativeXM), .RelativeYM(RelativeYM),
        .sprite_sel(sprite_sel), .sprite_hit(sprite_hit),
        .layer_hit(layer_hit), .commit_done(commit_done), .state_dbg(state_dbg)
    );

    always #5 vga_clk = ~vga_clk;

    always @(negedge vga_clk) if (commit_done) cd_cnt++;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] s, input logic [9:0] x, input logic [9:0] y,
                             input logic en);
        cfg_valid = 1'b1; cfg_slot = s; cfg_x = x; cfg_y = y; cfg_en = en;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic commit(input string tag);
        frame_start = 1'b1;
        tick();
        chk({tag, "_commit_done"}, commit_done, 1);
        chk({tag, "_ready_low"}, cfg_ready, 0);
        frame_start = 1'b0;
        tick();
        chk({tag, "_commit_end"}, commit_done, 0);
    endtask

    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y, input logic b,
                       input logic eh, input logic [1:0] es, input logic [9:0] erx,
                       input logic [9:0] ery);
        DrawX = x; DrawY = y; blank = b;
        tick();
        chk({tag, "_hit"}, sprite_hit, eh);
        if (eh) begin
            chk({tag, "_sel"}, sprite_sel, es);
            chk({tag, "_relx"}, RelativeXM, erx);
            chk({tag, "_rely"}, RelativeYM, ery);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_hit"}, sprite_hit, 0);
        chk({tag, "_layer"}, layer_hit, 0);
        chk({tag, "_sel"}, sprite_sel, 0);
        chk({tag, "_relx"}, RelativeXM, 0);
        chk({tag, "_rely"}, RelativeYM, 0);
        chk({tag, "_cdone"}, commit_done, 0);
    endtask

    initial begin
        Reset = 1'b1; frame_start = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0;
        cfg_valid = 1'b0; cfg_slot = '0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        tick();
        chk_idle("rst");
        chk("rst_ready", cfg_ready, 1);
        chk("rst_state", state_dbg, 0);

        // Slot 0 at origin is visible after a normal commit
        cfg_write(2'd0, 10'd0, 10'd0, 1'b1);
        commit("org");
        pix("org_px", 10'd0, 10'd0, 1'b1, 1'b1, 2'd0, 10'd0, 10'd0);

        // Reset asserted during COMMIT wipes both banks
        cfg_write(2'd0, 10'd0, 10'd0, 1'b1);
        DrawX = 10'd500; DrawY = 10'd400;
        frame_start = 1'b1;
        tick();
        chk("rc_in_commit", state_dbg, 1);
        frame_start = 1'b0;
        Reset = 1'b1;
        #1;
        chk_idle("rc_async");
        tick();
        Reset = 1'b0;
        tick();
        chk("rc_ready", cfg_ready, 1);
        chk("rc_state", state_dbg, 0);
        pix("rc_px", 10'd0, 10'd0, 1'b1, 1'b0, 2'd0, 10'd0, 10'd0);
        chk("rc_sel_zero", sprite_sel, 0);

        // Basic hit and layer_hit alignment
        cfg_write(2'd0, 10'd100, 10'd50, 1'b1);
        commit("basic");
        pix("basic_px", 10'd107, 10'd53, 1'b1, 1'b1, 2'd0, 10'd7, 10'd3);
        chk("lh_t0", layer_hit, 0);
        DrawX = 10'd500; DrawY = 10'd400;
        tick();
        chk("lh_t1", layer_hit, 0);
        chk("lh_t1_hit", sprite_hit, 0);
        tick();
        chk("lh_t2", layer_hit, 1);
        tick();
        chk("lh_t3", layer_hit, 0);

        // Overlap priority
        cfg_write(2'd0, 10'd100, 10'd100, 1'b1);
        cfg_write(2'd2, 10'd108, 10'd100, 1'b1);
        commit("ovl");
        pix("ovl_a", 10'd110, 10'd105, 1'b1, 1'b1, 2'd0, 10'd10, 10'd5);
        pix("ovl_b", 10'd117, 10'd105, 1'b1, 1'b1, 2'd2, 10'd9, 10'd5);

        // Edges, blank gating, and no wrap at the right screen edge
        cfg_write(2'd1, 10'd630, 10'd470, 1'b1);
        cfg_write(2'd3, 10'd1020, 10'd0, 1'b1);
        commit("edge");
        pix("edge_left", 10'd629, 10'd470, 1'b1, 1'b0, 2'd0, 10'd0, 10'd0);
        pix("edge_corner", 10'd645, 10'd485, 1'b1, 1'b1, 2'd1, 10'd15, 10'd15);
        pix("edge_right", 10'd646, 10'd470, 1'b1, 1'b0, 2'd0, 10'd0, 10'd0);
        pix("edge_blank", 10'd645, 10'd485, 1'b0, 1'b0, 2'd0, 10'd0, 10'd0);
        pix("wrap_in", 10'd1023, 10'd5, 1'b1, 1'b1, 2'd3, 10'd3, 10'd5);
        pix("wrap_out", 10'd2, 10'd5, 1'b1, 1'b0, 2'd0, 10'd0, 10'd0);

        // Shadow isolation
        cfg_write(2'd0, 10'd10, 10'd10, 1'b1);
        commit("shd");
        pix("shd_old", 10'd12, 10'd12, 1'b1, 1'b1, 2'd0, 10'd2, 10'd2);
        cfg_write(2'd0, 10'd200, 10'd200, 1'b1);
        pix("shd_still", 10'd12, 10'd12, 1'b1, 1'b1, 2'd0, 10'd2, 10'd2);
        pix("shd_notyet", 10'd202, 10'd202, 1'b1, 1'b0, 2'd0, 10'd0, 10'd0);
        commit("shd2");
        pix("shd_gone", 10'd12, 10'd12, 1'b1, 1'b0, 2'd0, 10'd0, 10'd0);
        pix("shd_new", 10'd202, 10'd202, 1'b1, 1'b1, 2'd0, 10'd2, 10'd2);

        // Write in the frame_start cycle, then a write stalled by COMMIT
        cd_cnt = 0;
        cfg_valid = 1'b1; cfg_slot = 2'd2; cfg_x = 10'd300; cfg_y = 10'd300; cfg_en = 1'b1;
        frame_start = 1'b1;
        chk("hs_ready_pre", cfg_ready, 1);
        tick();
        frame_start = 1'b0;
        chk("hs_cdone", commit_done, 1);
        chk("hs_stall", cfg_ready, 0);
        cfg_slot = 2'd3; cfg_x = 10'd400; cfg_y = 10'd400; cfg_en = 1'b1;
        tick();
        chk("hs_ready_back", cfg_ready, 1);
        chk("hs_cdone_end", commit_done, 0);
        tick();
        cfg_valid = 1'b0;
        chk("hs_pulses", cd_cnt, 1);
        pix("hs_in_commit", 10'd305, 10'd305, 1'b1, 1'b1, 2'd2, 10'd5, 10'd5);
        pix("hs_late_pending", 10'd405, 10'd405, 1'b1, 1'b0, 2'd0, 10'd0, 10'd0);
        commit("hs2");
        pix("hs_late_commit", 10'd405, 10'd405, 1'b1, 1'b1, 2'd3, 10'd5, 10'd5);

        // Back-to-back writes to one slot: last wins
        cfg_valid = 1'b1; cfg_slot = 2'd1; cfg_x = 10'd50; cfg_y = 10'd50; cfg_en = 1'b1;
        tick();
        cfg_x = 10'd60; cfg_y = 10'd60;
        tick();
        cfg_valid = 1'b0;
        commit("b2b");
        pix("b2b_first", 10'd52, 10'd52, 1'b1, 1'b0, 2'd0, 10'd0, 10'd0);
        pix("b2b_last", 10'd62, 10'd62, 1'b1, 1'b1, 2'd1, 10'd2, 10'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
